mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory (1-cycle read latency, block-RAM style) between the instruction-fetch requester and the data-memory requester of the multi-cycle CPU. It is placed between the CPU core and a unified instruction/data RAM, so one memory can replace the separate instruction-memory and `DataMemory` blocks. Arbitration is data-first, with a bounded-wait guarantee for fetch. Reads are pipelined, so the memory accepts one access per cycle.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_age_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified memory-port arbiter.
package mem_arb_pkg;

    // Which requester owns the read that is currently in flight
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int DEF_AW       = 32;
    localparam int DEF_DW       = 32;
    localparam int DEF_MAX_WAIT = 4;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating count of consecutive cycles the fetch request has been denied.
module arb_age_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [3:0] LIM = 4'(MAX_WAIT);

    logic [3:0] r_cnt;

    // Clear has precedence; increment stops at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     r_cnt <= 4'd0;
        else if (clr)                 r_cnt <= 4'd0;
        else if (inc && r_cnt != LIM) r_cnt <= r_cnt + 4'd1;
    end

    assign at_max = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-first arbiter sharing one single-port synchronous RAM between the
// instruction-fetch and data-memory requesters, with bounded fetch wait.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    logic   w_at_max;
    logic   w_if_gnt;
    logic   w_dm_gnt;
    owner_t r_owner;
    owner_t w_owner_nxt;

    // Fetch is forced only once it has waited MAX_WAIT cycles; reset blocks all grants
    assign w_if_gnt = rst & if_req & (w_at_max | ~dm_req);
    assign w_dm_gnt = rst & dm_req & ~(w_at_max & if_req);

    assign if_gnt = w_if_gnt;
    assign dm_gnt = w_dm_gnt;

    arb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
        .clk    (clk),
        .rst    (rst),
        .inc    (if_req & ~w_if_gnt),
        .clr    (w_if_gnt | ~if_req),
        .at_max (w_at_max)
    );

    // Steer the winner onto the memory port and pick the next read owner
    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_owner_nxt = OWN_NONE;
        if (w_if_gnt) begin
            mem_en      = 1'b1;
            mem_addr    = if_addr;
            w_owner_nxt = OWN_IF;
        end else if (w_dm_gnt) begin
            mem_en      = 1'b1;
            mem_we      = dm_we;
            mem_addr    = dm_addr;
            mem_wdata   = dm_wdata;
            w_owner_nxt = dm_we ? OWN_NONE : OWN_DM;
        end
    end

    // Owner reloads every cycle so reads can issue back to back; reset kills a pending rvalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_owner <= OWN_NONE;
        else      r_owner <= w_owner_nxt;
    end

    assign if_rvalid = (r_owner == OWN_IF);
    assign dm_rvalid = (r_owner == OWN_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign busy      = (r_owner != OWN_NONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] ram [logic [31:0]];

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read data one cycle after enable
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        mem_rdata = 32'h0;
        ram[32'h10] = 32'hE3A0_5001;
        ram[32'h20] = 32'hAAAA_0020;
        ram[32'h24] = 32'hBBBB_0024;
        ram[32'h50] = 32'hCCCC_0050;

        // Reset held with both requests up: everything quiet
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("rst_age", {28'd0, dut.u_age.r_cnt}, 32'd0);

        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);

        // Fetch-only read
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("fetch_gnt", {31'd0, if_gnt}, 32'd1);
        chk("fetch_mem_en", {31'd0, mem_en}, 32'd1);
        chk("fetch_mem_addr", mem_addr, 32'h10);
        @(posedge clk); #1;
        if_req = 1'b0;
        chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'hE3A0_5001);
        chk("fetch_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);

        // Data write then read back
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
        #1;
        chk("wr_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        @(posedge clk); #1;
        chk("wr_no_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        chk("wr_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        dm_we = 1'b0; dm_wdata = 32'h0;
        #1;
        chk("rd_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        chk("rd_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("rd_rdata", dm_rdata, 32'h1234_5678);
        chk("rd_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        dm_req = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Simultaneous requests, then starvation limit with dm held high
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("starve%0d_dm_gnt", i), {31'd0, dm_gnt}, 32'd1);
            chk($sformatf("starve%0d_if_gnt", i), {31'd0, if_gnt}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("starve%0d_age", i), {28'd0, dut.u_age.r_cnt}, i);
            @(negedge clk);
        end
        #1;
        chk("starve5_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("starve5_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        chk("starve5_mem_addr", mem_addr, 32'h10);
        @(posedge clk); #1;
        chk("starve5_age", {28'd0, dut.u_age.r_cnt}, 32'd0);
        chk("starve5_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("starve5_if_rdata", if_rdata, 32'hE3A0_5001);
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk);

        // Back-to-back alternating reads
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        #1; chk("b2b1_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("b2b1_rv", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
        chk("b2b1_data", if_rdata, 32'hAAAA_0020);
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h50;
        #1; chk("b2b2_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("b2b2_rv", {30'd0, if_rvalid, dm_rvalid}, 32'd1);
        chk("b2b2_data", dm_rdata, 32'hCCCC_0050);
        @(negedge clk);
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h24;
        #1; chk("b2b3_if_gnt", {31'd0, if_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("b2b3_rv", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
        chk("b2b3_data", if_rdata, 32'hBBBB_0024);

        // Reset asserted in the cycle after a fetch grant
        rst = 1'b0;
        #1;
        chk("rmid_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_mem_en", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        if_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rpost_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        chk("rpost_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
